// File: rtl/ex_commit_ctrl.sv
// ex_commit_ctrl: execute-stage commit controller.
//
// Holds one decoded instruction, decides whether it belongs to the current
// fetch stream, checks it for exceptions, and then either commits it (write
// strobes to regfile / load queue / store queue, optional fetch redirect) or
// takes a trap (redirect to trap_vec_i). Multi-cycle ops (MUL/DIV) and a full
// load/store queue stall the decoder while the instruction stays held.
//
// Ports:
//   clk_i, resetb_i, clk_en_i    clock, async active-low reset, global enable
//   ids_*                        decoded instruction from the decoder
//   ids_stall_o                  back-pressure to the decoder
//   alu_result_i, alu_cmp_i      ALU result / compare of the held instruction
//   trap_vec_i                   trap entry address
//   mc_start_o, mc_done_i        multi-cycle unit handshake
//   lsq_full_i                   load/store queue full
//   regd_wr_o, lq_wr_o, sq_wr_o  commit strobes
//   cncl_load_o                  cancel scoreboarded load of a dropped instruction
//   hvec_jump_o, hvec_addr_o     fetch redirect
//   trap_o, trap_cause_o, trap_pc_o  exception report
//   link_data_o                  return address (pc + instruction length)
module ex_commit_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned C_EXT   = 0,
  parameter int unsigned SOFID_W = 2
) (
  input  logic               clk_i,
  input  logic               resetb_i,
  input  logic               clk_en_i,
  input  logic               ids_valid_i,
  output logic               ids_stall_o,
  input  logic [SOFID_W-1:0] ids_sofid_i,
  input  logic               ids_jump_i,
  input  logic               ids_cond_i,
  input  logic               ids_ferr_i,
  input  logic               ids_uerr_i,
  input  logic [1:0]         ids_zone_i,
  input  logic               ids_mc_i,
  input  logic [2:0]         ids_funct3_i,
  input  logic [XLEN-1:0]    ids_pc_i,
  input  logic               ids_ins_len_i,
  input  logic [XLEN-1:0]    alu_result_i,
  input  logic               alu_cmp_i,
  input  logic [XLEN-1:0]    trap_vec_i,
  output logic               mc_start_o,
  input  logic               mc_done_i,
  input  logic               lsq_full_i,
  output logic               regd_wr_o,
  output logic               lq_wr_o,
  output logic               sq_wr_o,
  output logic               cncl_load_o,
  output logic               hvec_jump_o,
  output logic [XLEN-1:0]    hvec_addr_o,
  output logic               trap_o,
  output logic [3:0]         trap_cause_o,
  output logic [XLEN-1:0]    trap_pc_o,
  output logic [XLEN-1:0]    link_data_o
);

  localparam logic [1:0] ZoneReg   = 2'd1;
  localparam logic [1:0] ZoneLoad  = 2'd2;
  localparam logic [1:0] ZoneStore = 2'd3;

  typedef enum logic [0:0] {StIdle, StBusy} mc_state_e;

  // Hold stage
  logic               valid_q;
  logic [SOFID_W-1:0] sofid_q;
  logic               jump_q;
  logic               cond_q;
  logic               ferr_q;
  logic               uerr_q;
  logic [1:0]         zone_q;
  logic               mc_q;
  logic [1:0]         funct3_q;  // only the size bits matter for alignment
  logic [XLEN-1:0]    pc_q;
  logic               ins_len_q;

  logic [SOFID_W-1:0] exp_q;
  mc_state_e          st_q;

  logic       en;
  logic       ex_valid;
  logic       fetch_mis;
  logic       ls_mis;
  logic       exc;
  logic [3:0] cause;
  logic       trap;
  logic       commit;
  logic       lsq_stall;
  logic       mc_go;
  logic       mc_stall;
  logic [2:0] lo;

  assign lo = alu_result_i[2:0];

  // Instructions from a stream that has since been redirected away are dead.
  assign ex_valid = valid_q & (sofid_q == exp_q) & (~cond_q | alu_cmp_i);

  always_comb begin
    fetch_mis = 1'b0;
    if (jump_q) begin
      fetch_mis = (C_EXT != 0) ? lo[0] : |lo[1:0];
    end
    case (funct3_q)
      2'b01:   ls_mis = lo[0];
      2'b10:   ls_mis = |lo[1:0];
      2'b11:   ls_mis = (XLEN == 64) ? |lo : 1'b0;
      default: ls_mis = 1'b0;
    endcase
  end

  // Exception priority: fetch error, undefined, misaligned target, misaligned access.
  always_comb begin
    exc   = 1'b1;
    cause = 4'd0;
    if (ferr_q) begin
      cause = 4'd1;
    end else if (uerr_q) begin
      cause = 4'd2;
    end else if (fetch_mis) begin
      cause = 4'd0;
    end else if (zone_q == ZoneLoad && ls_mis) begin
      cause = 4'd4;
    end else if (zone_q == ZoneStore && ls_mis) begin
      cause = 4'd6;
    end else begin
      exc = 1'b0;
    end
  end

  assign trap   = ex_valid & exc;
  assign commit = ex_valid & ~exc;

  assign lsq_stall   = commit & ((zone_q == ZoneLoad) | (zone_q == ZoneStore)) & lsq_full_i;
  assign mc_go       = (st_q == StIdle) & commit & mc_q & clk_en_i;
  // Done releases the stall in the same cycle so the result commits then.
  assign mc_stall    = mc_go | ((st_q == StBusy) & ~mc_done_i);
  assign ids_stall_o = lsq_stall | mc_stall;
  assign en          = clk_en_i & ~ids_stall_o;

  assign mc_start_o   = mc_go;
  assign regd_wr_o    = en & commit & (zone_q == ZoneReg);
  assign lq_wr_o      = en & commit & (zone_q == ZoneLoad);
  assign sq_wr_o      = en & commit & (zone_q == ZoneStore);
  assign cncl_load_o  = en & valid_q & (zone_q == ZoneLoad) & ~commit;
  assign hvec_jump_o  = en & (trap | (commit & jump_q));
  assign hvec_addr_o  = trap ? trap_vec_i : alu_result_i;
  assign trap_o       = en & trap;
  assign trap_cause_o = trap_o ? cause : 4'd0;
  assign trap_pc_o    = pc_q;
  assign link_data_o  = pc_q + (((C_EXT != 0) && ins_len_q) ? XLEN'(2) : XLEN'(4));

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      valid_q   <= 1'b0;
      sofid_q   <= '0;
      jump_q    <= 1'b0;
      cond_q    <= 1'b0;
      ferr_q    <= 1'b0;
      uerr_q    <= 1'b0;
      zone_q    <= 2'd0;
      mc_q      <= 1'b0;
      funct3_q  <= 2'd0;
      pc_q      <= '0;
      ins_len_q <= 1'b0;
      exp_q     <= '0;
      st_q      <= StIdle;
    end else if (clk_en_i) begin
      case (st_q)
        StIdle:  if (mc_go) st_q <= StBusy;
        StBusy:  if (mc_done_i) st_q <= StIdle;
        default: st_q <= StIdle;
      endcase
      // hvec_jump_o already carries en, so a stall freezes the stream id too.
      if (hvec_jump_o) begin
        exp_q <= exp_q + SOFID_W'(1);
      end
      if (en) begin
        valid_q   <= ids_valid_i;
        sofid_q   <= ids_sofid_i;
        jump_q    <= ids_jump_i;
        cond_q    <= ids_cond_i;
        ferr_q    <= ids_ferr_i;
        uerr_q    <= ids_uerr_i;
        zone_q    <= ids_zone_i;
        mc_q      <= ids_mc_i;
        funct3_q  <= ids_funct3_i[1:0];
        pc_q      <= ids_pc_i;
        ins_len_q <= ids_ins_len_i;
      end
    end
  end

endmodule

// File: doc/ex_commit_ctrl.md
EX_COMMIT_CTRL -- requirements
Module: ex_commit_ctrl

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath width (32 or 64); C_EXT, default 0, 1 = 16-bit instruction alignment; SOFID_W, default 2, stream-id width.
REQ-002 SHALL have ports, in this order:
- clk_i  in  1  clock; all state on rising edge.
- resetb_i  in  1  reset, asynchronous, active-low.
- clk_en_i  in  1  global clock enable; when 0 all state holds.
- ids_valid_i  in  1  decoder instruction valid.
- ids_stall_o  out  1  stall to decoder.
- ids_sofid_i  in  SOFID_W  stream id of the instruction.
- ids_jump_i, ids_cond_i  in  1  jump; conditional (branch).
- ids_ferr_i, ids_uerr_i  in  1  fetch error; undefined instruction.
- ids_zone_i  in  2  destination: 0 none, 1 regfile, 2 load queue, 3 store queue.
- ids_mc_i  in  1  multi-cycle op (MUL/DIV).
- ids_funct3_i  in  3  width code.
- ids_pc_i  in  XLEN  instruction PC.
- ids_ins_len_i  in  1  1 = 16-bit instruction; ignored when C_EXT=0.
- alu_result_i  in  XLEN  ALU result / target / effective address of the held instruction.
- alu_cmp_i  in  1  branch compare result of the held instruction.
- trap_vec_i  in  XLEN  trap entry address.
- mc_start_o  out  1  multi-cycle unit start pulse.
- mc_done_i  in  1  multi-cycle unit result ready.
- lsq_full_i  in  1  load/store queue full.
- regd_wr_o, lq_wr_o, sq_wr_o  out  1  commit strobes.
- cncl_load_o  out  1  cancel scoreboarded load of a squashed instruction.
- hvec_jump_o  out  1  redirect fetch.
- hvec_addr_o  out  XLEN  redirect address.
- trap_o  out  1  exception taken.
- trap_cause_o  out  4  mcause code.
- trap_pc_o  out  XLEN  faulting PC.
- link_data_o  out  XLEN  PC + instruction length.

Function
REQ-003 SHALL register all ids_* inputs into a hold stage when stage enable (en = clk_en_i & ~ids_stall_o) is 1; link_data_o = held pc + 2 if C_EXT & ins_len, else + 4, modulo 2^XLEN.
REQ-004 SHALL keep expected-stream register exp_q (reset 0); on any redirect (hvec_jump_o & en), exp_q <= exp_q + 1 mod 2^SOFID_W, wrapping from 2^SOFID_W-1 to 0.
REQ-005 SHALL define ex_valid = valid_q & (sofid_q == exp_q) & (~cond_q | alu_cmp_i); an instruction with stale sofid SHALL produce no strobe, trap or jump.
REQ-006 SHALL raise misalignment on target/address bits: jump target bit[1] (C_EXT=0) or bit[0] must be 0 (C_EXT=1 requires bit[0]=0 only); funct3[1:0]=01 requires bit[0]=0; 10 requires bits[1:0]=0; 11 (XLEN=64 only) requires bits[2:0]=0.
REQ-007 SHALL prioritise exceptions ferr(cause 1) > uerr(2) > misaligned fetch(0) > misaligned load(4) / store(6); trap = ex_valid & any exception; commit = ex_valid & ~trap.
REQ-008 On trap: trap_o=1, hvec_jump_o=1, hvec_addr_o=trap_vec_i, trap_pc_o=pc_q, no commit strobes; otherwise hvec_addr_o=alu_result_i.
REQ-009 SHALL assert regd_wr_o/lq_wr_o/sq_wr_o = en & commit & zone match; hvec_jump_o = en & (trap | commit & jump_q).
REQ-010 SHALL assert cncl_load_o = en & valid_q & zone_q==2 & ~commit.
REQ-011 Multi-cycle FSM states IDLE, BUSY: IDLE->BUSY when commit & mc_q & clk_en_i (mc_start_o=1 for that cycle only); BUSY->IDLE when mc_done_i; stall asserted in IDLE-with-start and throughout BUSY until done; regd_wr_o fires in the done cycle.
REQ-012 ids_stall_o = (commit & (zone_q==2|3) & lsq_full_i) | mc stall; while stalled held state and exp_q SHALL not change.
REQ-013 mc_done_i in IDLE SHALL be ignored; mc_done_i in the start cycle SHALL not be accepted.

Reset
REQ-014 Async reset SHALL clear valid_q, exp_q=0, FSM=IDLE; all outputs 0 except data buses, which are don't-care; reset mid-BUSY abandons the op without strobes.

Verification
REQ-015 ALU op zone 1, sofid 0 -> regd_wr_o=1 next cycle, no stall.
REQ-016 JAL pc 0x100, target 0x202, C_EXT=0 -> trap_o=1, cause 0, hvec_addr_o=trap_vec_i, trap_pc_o=0x100; next instruction with sofid 0 squashed, sofid 1 accepted.
REQ-017 LW addr 0x1002, lsq_full_i=0 -> trap cause 4, cncl_load_o=1, lq_wr_o=0.
REQ-018 SW addr 0x1000, lsq_full_i=1 for 3 cycles -> ids_stall_o=1 for 3 cycles, sq_wr_o=1 once on release.
REQ-019 MUL, mc_done_i 5 cycles after start -> mc_start_o single pulse, stall 5 cycles, one regd_wr_o; reset in cycle 3 -> no strobes, FSM IDLE.
REQ-020 SOFID_W=2, four redirects -> exp_q wraps 3->0; ferr+uerr together -> cause 1.
